mems_frame_reader: RTL and testbench

//  Downstream stage of the on-chip MEMS frame buffer: Avalon-MM read master that fetches one frame
//  (FRAME_WORDS words, addresses 0..FRAME_WORDS-1) per start pulse.

---
 rtl/mems_pkg.sv | 17 +
 rtl/mems_frame_reader_if.sv | 29 ++
 rtl/mems_stream_fifo.sv | 51 +++++
 rtl/mems_frame_reader.sv | 138 +++++++++++++
 tb/tb_mems_frame_reader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mems_pkg.sv
// Shared definitions for the MEMS frame reader slice.
//   state_t          : reader FSM states
//   DEF_FRAME_WORDS  : default words per frame (matches the buffer writer fill range)
//   DEF_FIFO_DEPTH   : default output FIFO depth
//   cnt_w(n)         : bits needed to hold the values 0..n
package mems_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int DEF_FRAME_WORDS = 4095;
  localparam int DEF_FIFO_DEPTH  = 8;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mems_frame_reader_if.sv
// Bus bundle for the frame reader: Avalon-MM read master side plus the
// outgoing valid/ready stream.
//   master : the reader (drives address/read and the stream)
//   slave  : memory + stream sink (drives readdata/readdatavalid/waitrequest, st_ready)
interface mems_frame_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_valid;
  logic                  st_ready;
  logic                  st_sop;
  logic                  st_eop;

  modport master (
    output address, read, st_data, st_valid, st_sop, st_eop,
    input  readdata, readdatavalid, waitrequest, st_ready
  );

  modport slave (
    input  address, read, st_data, st_valid, st_sop, st_eop,
    output readdata, readdatavalid, waitrequest, st_ready
  );
endinterface

// File: rtl/mems_stream_fifo.sv
// Synchronous FIFO between Avalon read returns and the output stream.
// Ports: clock, reset (sync, active low), push/din, pop/dout (show-ahead head),
// full, empty, count. Push on a full FIFO is taken when a pop happens in the
// same cycle; pop on empty is ignored. DEPTH must be a power of two.
module mems_stream_fifo
  import mems_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int CW    = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/mems_frame_reader.sv
// Avalon-MM read master that fetches one frame (words 0..FRAME_WORDS-1) per
// accepted start pulse and streams it out with sop/eop framing.
// Ports:
//   clock, reset        : clock, synchronous active-low reset
//   start               : begin a frame (ignored while busy)
//   busy                : accepted start until the eop word is handed off
//   frame_done          : one-cycle pulse after the eop handshake
//   error_count         : pattern mismatches in the current frame
//   bus (master)        : Avalon address/read/readdata/readdatavalid/waitrequest
//                         and stream st_data/st_valid/st_ready/st_sop/st_eop
// Build option: define PATTERN_CHECK_EN to compare every returned word with its
// zero-extended word index; otherwise error_count is tied to zero.
module mems_frame_reader
  import mems_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] error_count,
  mems_frame_reader_if.master bus
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int IW = cnt_w(FRAME_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(FRAME_WORDS - 1);
  localparam logic [CW:0]           DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         outstanding, fifo_count;
  logic [IW-1:0]         out_idx;
  logic [CW:0]           inflight;
  logic                  start_ok, accept, rsp_ok, pop, eop_pop;
  logic                  fifo_full, fifo_empty;

  // Credit: words in the FIFO plus reads in flight never exceed the FIFO
  // depth, so every return has a slot. The sum cannot grow while a request
  // is stalled, so read stays asserted under waitrequest.
  assign inflight    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign bus.read    = (state == ISSUE) && !fifo_full && (inflight < DEPTH_C);
  assign bus.address = addr_q;
  assign accept      = bus.read && !bus.waitrequest;
  // Returns with nothing outstanding belong to a frame killed by reset.
  assign rsp_ok      = bus.readdatavalid && (outstanding != '0);

  assign bus.st_valid = !fifo_empty;
  assign pop          = bus.st_valid && bus.st_ready;
  assign eop_pop      = pop && (out_idx == LAST_IDX);
  assign bus.st_sop   = bus.st_valid && (out_idx == '0);
  assign bus.st_eop   = bus.st_valid && (out_idx == LAST_IDX);

  assign start_ok = start && (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (accept && (addr_q == LAST_ADDR)) state_nx = DRAIN;
      DRAIN:   if (eop_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      out_idx     <= '0;
      outstanding <= '0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= eop_pop;
      if (start_ok) begin
        addr_q  <= '0;
        out_idx <= '0;
      end else begin
        // Address parks on the last word once it has been accepted.
        if (accept && (addr_q != LAST_ADDR)) addr_q <= addr_q + 1'b1;
        if (pop) out_idx <= out_idx + 1'b1;
      end
      unique case ({accept, rsp_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  mems_stream_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rsp_ok),
    .din   (bus.readdata),
    .pop   (pop),
    .dout  (bus.st_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef PATTERN_CHECK_EN
  logic [IW-1:0] rsp_idx;
  logic [15:0]   err_q;

  // Returns arrive in request order, so a running count is the word index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_idx <= '0;
      err_q   <= '0;
    end else if (start_ok) begin
      rsp_idx <= '0;
      err_q   <= '0;
    end else if (rsp_ok) begin
      rsp_idx <= rsp_idx + 1'b1;
      if ((bus.readdata != DATA_WIDTH'(rsp_idx)) && (err_q != 16'hFFFF))
        err_q <= err_q + 1'b1;
    end
  end

  assign error_count = err_q;
`else
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_mems_frame_reader.sv
// Self-checking bench for mems_frame_reader: an Avalon slave with a word array
// and configurable latency/stalls, a stream sink with configurable back-pressure,
// and a frame-level reference (expected stream = mem[0..FW-1] in order).
module tb_mems_frame_reader;

  localparam int FW    = 4095;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, frame_done;
  logic [15:0] error_count;

  always #5 clock = ~clock;

  mems_frame_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mems_frame_reader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FRAME_WORDS(FW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .frame_done  (frame_done),
    .error_count (error_count),
    .bus         (bus)
  );

  typedef struct {int addr; int due; bit live;} rsp_t;
  rsp_t        pend[$];
  logic [31:0] mem [FW];

  int n_vec = 0, n_err = 0, cyc = 0;
  int lat = 1, mode_wr = 0, mode_rdy = 0, ready_off = 0, stall_left = 0;
  int accepts = 0, pops = 0, exp_idx = 0, exp_addr = 0, fd_cnt = 0;
  bit stalled_cur, prev_stall, prev_rdv, check_full, start_pulse, chain_req, chained;
  bit rst_drv = 1'b0;
  logic [31:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, then sample #1 later and
  // account for the handshakes the next rising edge will complete.
  task automatic step();
    bit live_rdv;
    @(negedge clock);
    cyc++;
    reset = rst_drv;
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
    live_rdv          = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      bus.readdatavalid = 1'b1;
      bus.readdata = (pend[0].addr >= 0 && pend[0].addr < FW) ? mem[pend[0].addr] : 32'hBAD0BAD0;
      live_rdv = pend[0].live;
      pend.delete(0);
    end
    if (mode_wr == 1 && bus.read && stall_left == 0 && !stalled_cur && accepts % 5 == 4) begin
      stall_left  = 3;
      stalled_cur = 1'b1;
    end
    if (stall_left > 0) begin
      bus.waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.waitrequest = (mode_wr == 2) ? ($urandom_range(3) == 0) : 1'b0;
    end
    check_full = 1'b0;
    if (ready_off > 0) begin
      bus.st_ready = 1'b0;
      ready_off--;
      check_full = (ready_off == 0);
    end else begin
      bus.st_ready = (mode_rdy == 1) ? ($urandom_range(3) != 0) : 1'b1;
    end
    start = start_pulse || (chain_req && frame_done);
    if (chain_req && frame_done) begin
      chain_req = 1'b0;
      chained   = 1'b1;
    end
    start_pulse = 1'b0;
    #1;
    if (prev_stall) begin
      chk("rd_hold", 32'(bus.read), 1);
      chk("addr_hold", bus.address, prev_addr);
    end
    if (prev_rdv) chk("rdv_to_valid", 32'(bus.st_valid), 1);
    if (bus.read) chk("credit", 32'(accepts - pops < DEPTH), 1);
    if (check_full) begin
      chk("rd_off_full", 32'(bus.read), 0);
      chk("inflight_full", accepts - pops, DEPTH);
    end
    if (bus.read && !bus.waitrequest) begin
      chk("addr", bus.address, exp_addr);
      pend.push_back('{int'(bus.address), cyc + lat, bit'(rst_drv)});
      exp_addr++;
      accepts++;
      stalled_cur = 1'b0;
    end
    prev_stall = bus.read && bus.waitrequest;
    prev_addr  = bus.address;
    prev_rdv   = live_rdv;
    if (bus.st_valid && bus.st_ready) begin
      if (exp_idx < FW) begin
        chk("data", bus.st_data, mem[exp_idx]);
        chk("sop", 32'(bus.st_sop), 32'(exp_idx == 0));
        chk("eop", 32'(bus.st_eop), 32'(exp_idx == FW - 1));
      end else begin
        chk("extra_word", exp_idx, FW - 1);
      end
      exp_idx++;
      pops++;
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic new_frame();
    accepts = 0; pops = 0; exp_idx = 0; exp_addr = 0; fd_cnt = 0;
    stalled_cur = 1'b0; stall_left = 0;
  endtask

  task automatic do_abort();
    foreach (pend[i]) pend[i].live = 1'b0;
    rst_drv = 1'b0;
    step();
    rst_drv    = 1'b1;
    prev_stall = 1'b0;
    prev_rdv   = 1'b0;
    ready_off  = 0;
    new_frame();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rst_read", 32'(bus.read), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(bus.st_valid), 0);
      if (i == 0) begin
        chk("rst_addr", bus.address, 0);
        chk("rst_err", 32'(error_count), 0);
      end
    end
  endtask

  task automatic run_frame(input int l, input int wr, input int rdy, input int hold_at,
                           input bit busy_starts, input bit chain, input int abort_at);
    int exp_err, n;
    bit held;
    lat = l; mode_wr = wr; mode_rdy = rdy;
    exp_err = 0;
`ifdef PATTERN_CHECK_EN
    for (int i = 0; i < FW; i++) if (mem[i] != 32'(i)) exp_err++;
`endif
    if (!chained) begin
      start_pulse = 1'b1;
      step();
    end
    chained = 1'b0;
    new_frame();
    step();
    chk("start_to_read", 32'(bus.read), 1);
    chk("busy", 32'(busy), 1);
    chk("err_clear", 32'(error_count), 0);
    chain_req = chain;
    held = 1'b0;
    n = 0;
    while (fd_cnt == 0 && n < 20000) begin
      if (hold_at > 0 && !held && exp_idx >= hold_at) begin
        ready_off = 100;
        held = 1'b1;
      end
      if (busy_starts && exp_idx < FW - 16 && $urandom_range(199) == 0) start_pulse = 1'b1;
      if (abort_at > 0 && exp_addr >= abort_at) begin
        do_abort();
        return;
      end
      step();
      n++;
    end
    chk("frame_timeout", 32'(fd_cnt != 0), 1);
    chk("words", exp_idx, FW);
    chk("reads", exp_addr, FW);
    chk("err_count", 32'(error_count), exp_err);
    if (!chained) begin
      step();
      chk("done_pulse", 32'(frame_done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(bus.st_valid), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < FW; i++) mem[i] = 32'(i);
    repeat (3) step();
    rst_drv = 1'b1;
    step();
    chk("reset_read", 32'(bus.read), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(frame_done), 0);
    chk("reset_valid", 32'(bus.st_valid), 0);
    chk("reset_err", 32'(error_count), 0);
    chk("reset_addr", bus.address, 0);

    // plain frame, 1-cycle latency, mem[i]=i
    run_frame(1, 0, 0, 0, 1'b0, 1'b0, 0);
    // random data, 3-cycle stall on every 5th read
    for (int i = 0; i < FW; i++) mem[i] = $urandom();
    run_frame(2, 1, 0, 0, 1'b0, 1'b0, 0);
    // sink stalls 100 cycles mid-frame with 4-cycle latency
    run_frame(4, 0, 0, 1000, 1'b0, 1'b0, 0);
    // two pattern mismatches, then a clean frame with random timing,
    // ignored starts while busy and a start in the frame_done cycle
    for (int i = 0; i < FW; i++) mem[i] = 32'(i);
    mem[10] = 32'hDEAD;
    mem[20] = 32'h0;
    run_frame(1, 0, 0, 0, 1'b0, 1'b0, 0);
    mem[10] = 32'd10;
    mem[20] = 32'd20;
    run_frame($urandom_range(5, 1), 2, 1, 0, 1'b1, 1'b1, 0);
    run_frame(1, 0, 0, 0, 1'b0, 1'b0, 0);
    // reset mid-frame with reads in flight, then a fresh frame
    run_frame(3, 0, 0, 0, 1'b0, 1'b0, 2000);
    run_frame(3, 0, 0, 0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
